// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - two-requester round-robin controller for a single-port sync RAM with zero-fill init
module ram_rr_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_in,
   input  logic                  we0_in,
   input  logic [ADDR_WIDTH-1:0] addr0_in,
   input  logic [DATA_WIDTH-1:0] wdata0_in,
   output logic                  gnt0_out,
   output logic                  rvalid0_out,
   input  logic                  req1_in,
   input  logic                  we1_in,
   input  logic [ADDR_WIDTH-1:0] addr1_in,
   input  logic [DATA_WIDTH-1:0] wdata1_in,
   output logic                  gnt1_out,
   output logic                  rvalid1_out,
   output logic [DATA_WIDTH-1:0] rdata_out,
   output logic                  init_done_out,
   output logic [DATA_WIDTH-1:0] ram_data_in_out,
   output logic [ADDR_WIDTH-1:0] ram_read_addr_out,
   output logic [ADDR_WIDTH-1:0] ram_write_addr_out,
   output logic                  ram_we_out,
   input  logic [DATA_WIDTH-1:0] ram_data_out_in
);

   // Counter is one bit wider than the address so that reaching DEPTH marks
   // the end of the zero-fill without a separate flag.
   localparam logic [ADDR_WIDTH:0] INIT_END = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  init_done_q, init_done_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   // Read-return pipeline: stage 1 = address on RAM, stage 2 = data on RAM output.
   logic                  p1_vld_q, p1_vld_d;
   logic                  p1_own_q, p1_own_d;
   logic                  p2_vld_q, p2_vld_d;
   logic                  p2_own_q, p2_own_d;
   logic                  rvalid0_q, rvalid0_d;
   logic                  rvalid1_q, rvalid1_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  gnt0, gnt1;
   logic                  xfer;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Round-robin grant: no grants during init; on contention the requester
   // that was not served last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == ST_RUN) begin
         if (req0_in && req1_in) begin
            if (last_q) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = req0_in;
            gnt1 = req1_in;
         end
      end
   end

   // Mux the winning requester's command onto a single issue path.
   always_comb begin
      xfer      = gnt0 | gnt1;
      sel_we    = gnt1 ? we1_in    : we0_in;
      sel_addr  = gnt1 ? addr1_in  : addr0_in;
      sel_wdata = gnt1 ? wdata1_in : wdata0_in;
   end

   // Next-state logic: init zero-fill, command issue and read-return tagging.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      init_done_d = init_done_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      wdata_d     = wdata_q;
      p1_vld_d    = 1'b0;
      p1_own_d    = p1_own_q;
      p2_vld_d    = p1_vld_q;
      p2_own_d    = p1_own_q;
      rvalid0_d   = p2_vld_q & ~p2_own_q;
      rvalid1_d   = p2_vld_q &  p2_own_q;
      rdata_d     = p2_vld_q ? ram_data_out_in : rdata_q;

      case (state_q)
         ST_INIT: begin
            if (cnt_q == INIT_END) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end else begin
               we_d    = 1'b1;
               waddr_d = cnt_q[ADDR_WIDTH-1:0];
               wdata_d = '0;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               last_d = gnt1;
               if (sel_we) begin
                  we_d    = 1'b1;
                  waddr_d = sel_addr;
                  wdata_d = sel_wdata;
               end else begin
                  raddr_d  = sel_addr;
                  p1_vld_d = 1'b1;
                  p1_own_d = gnt1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State register; reset discards in-flight reads and restarts the zero-fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         init_done_q <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         wdata_q     <= '0;
         p1_vld_q    <= 1'b0;
         p1_own_q    <= 1'b0;
         p2_vld_q    <= 1'b0;
         p2_own_q    <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         init_done_q <= init_done_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         wdata_q     <= wdata_d;
         p1_vld_q    <= p1_vld_d;
         p1_own_q    <= p1_own_d;
         p2_vld_q    <= p2_vld_d;
         p2_own_q    <= p2_own_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata_q     <= rdata_d;
      end
   end

   // Drive ports from registers (grants stay combinational).
   always_comb begin
      gnt0_out           = gnt0;
      gnt1_out           = gnt1;
      rvalid0_out        = rvalid0_q;
      rvalid1_out        = rvalid1_q;
      rdata_out          = rdata_q;
      init_done_out      = init_done_q;
      ram_we_out         = we_q;
      ram_write_addr_out = waddr_q;
      ram_read_addr_out  = raddr_q;
      ram_data_in_out    = wdata_q;
   end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb/tb_ram_rr_arbiter.sv - directed and randomized checks of ram_rr_arbiter against a transaction-level model
module tb_ram_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0, we0, req1, we1;
   logic [5:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
   logic [7:0] rdata, ram_din, ram_dout;
   logic [5:0] ram_raddr, ram_waddr;

   ram_rr_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req0_in            (req0),
      .we0_in             (we0),
      .addr0_in           (addr0),
      .wdata0_in          (wdata0),
      .gnt0_out           (gnt0),
      .rvalid0_out        (rvalid0),
      .req1_in            (req1),
      .we1_in             (we1),
      .addr1_in           (addr1),
      .wdata1_in          (wdata1),
      .gnt1_out           (gnt1),
      .rvalid1_out        (rvalid1),
      .rdata_out          (rdata),
      .init_done_out      (init_done),
      .ram_data_in_out    (ram_din),
      .ram_read_addr_out  (ram_raddr),
      .ram_write_addr_out (ram_waddr),
      .ram_we_out         (ram_we),
      .ram_data_out_in    (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM; filled with non-zero junk while reset is low so the
   // zero-fill has something to clear.
   logic [7:0] ram [64];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) ram[i] <= 8'h5A ^ 8'(i);
      end else if (ram_we) begin
         ram[ram_waddr] <= ram_din;
      end
      ram_dout <= ram[ram_raddr];
   end

   // Transaction-level model: memory contents in accept order, expected read returns.
   typedef struct {
      bit       own;
      bit [7:0] data;
      int       due;
   } rd_t;

   int       tests;
   int       fails;
   int       cyc;
   bit [7:0] mem_model [64];
   rd_t      rq [$];
   bit       run_model;
   bit       last_model;
   bit [7:0] exp_rdata;
   bit       g0, g1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt0"},   32'(gnt0), 32'd0);
      chk({tag, "_gnt1"},   32'(gnt1), 32'd0);
      chk({tag, "_rv0"},    32'(rvalid0), 32'd0);
      chk({tag, "_rv1"},    32'(rvalid1), 32'd0);
      chk({tag, "_rdata"},  32'(rdata), 32'd0);
      chk({tag, "_idone"},  32'(init_done), 32'd0);
      chk({tag, "_we"},     32'(ram_we), 32'd0);
      chk({tag, "_raddr"},  32'(ram_raddr), 32'd0);
      chk({tag, "_waddr"},  32'(ram_waddr), 32'd0);
      chk({tag, "_din"},    32'(ram_din), 32'd0);
   endtask

   // Called at a negedge right after rst_n rises; follows the whole zero-fill.
   task automatic run_init(input bit exp_g0);
      #1;
      chk("init_k0_we", 32'(ram_we), 32'd0);
      chk("init_k0_gnt0", 32'(gnt0), 32'd0);
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk);
         #1;
         if (k <= 64) begin
            chk("init_we", 32'(ram_we), 32'd1);
            chk("init_waddr", 32'(ram_waddr), 32'(k - 1));
            chk("init_din", 32'(ram_din), 32'd0);
            chk("init_done_low", 32'(init_done), 32'd0);
            chk("init_gnt0", 32'(gnt0), 32'd0);
            chk("init_gnt1", 32'(gnt1), 32'd0);
         end else begin
            chk("init_end_we", 32'(ram_we), 32'd0);
            chk("init_done_high", 32'(init_done), 32'd1);
            chk("init_first_gnt0", 32'(gnt0), 32'(exp_g0));
            chk("init_first_gnt1", 32'(gnt1), 32'd0);
         end
      end
      for (int i = 0; i < 64; i++) mem_model[i] = 8'h00;
      run_model  = 1'b1;
      last_model = 1'b1;
   endtask

   // One RUN cycle with inputs already applied at the current negedge.
   task automatic do_cycle();
      bit       w, rd, own, p0, p1;
      bit [5:0] a;
      bit [7:0] d;
      rd_t      ent;
      #1;
      g0 = 1'b0;
      g1 = 1'b0;
      if (run_model) begin
         if (req0 && req1) begin
            g0 = last_model;
            g1 = !last_model;
         end else begin
            g0 = req0;
            g1 = req1;
         end
      end
      chk("gnt0", 32'(gnt0), 32'(g0));
      chk("gnt1", 32'(gnt1), 32'(g1));
      w  = 1'b0;
      rd = 1'b0;
      if (g0 || g1) begin
         own        = g1;
         last_model = own;
         w          = own ? we1 : we0;
         rd         = !w;
         a          = own ? addr1 : addr0;
         d          = own ? wdata1 : wdata0;
         if (w) mem_model[a] = d;
         else rq.push_back('{own: own, data: mem_model[a], due: cyc + 3});
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("ram_we", 32'(ram_we), 32'(w));
      if (w) begin
         chk("ram_waddr", 32'(ram_waddr), 32'(a));
         chk("ram_din", 32'(ram_din), 32'(d));
      end
      if (rd) chk("ram_raddr", 32'(ram_raddr), 32'(a));
      p0 = 1'b0;
      p1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         ent       = rq.pop_front();
         p0        = !ent.own;
         p1        = ent.own;
         exp_rdata = ent.data;
      end
      chk("rvalid0", 32'(rvalid0), 32'(p0));
      chk("rvalid1", 32'(rvalid1), 32'(p1));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
   endtask

   task automatic idle(input int n);
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < n; i++) do_cycle();
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0;
      run_model = 1'b0; last_model = 1'b1; exp_rdata = 8'h00;
      rst_n = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

      // Reset state, then release with both requesters pending through init.
      repeat (3) @(negedge clk);
      req0 = 1'b1;
      req1 = 1'b1;
      #1;
      chk_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      run_init(1'b1);
      req0 = 1'b0;
      req1 = 1'b0;

      // Write then read back through requester 0.
      req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 8'hA5;
      do_cycle();
      we0 = 1'b0;
      do_cycle();
      idle(3);

      // Never-written address reads back zero through requester 1.
      req1 = 1'b1; we1 = 1'b0; addr1 = 6'd33;
      do_cycle();
      idle(3);

      // Preload via requester 1, then contend for 6 cycles; 0 must win first.
      req1 = 1'b1; we1 = 1'b1; addr1 = 6'd10; wdata1 = 8'h11;
      do_cycle();
      addr1 = 6'd20; wdata1 = 8'h22;
      do_cycle();
      req0 = 1'b1; we0 = 1'b0; addr0 = 6'd10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 6'd20;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("alt_gnt0", 32'(gnt0), 32'((i % 2) == 0));
         do_cycle();
      end
      idle(3);

      // Write by 1 followed immediately by read of same address by 0.
      req1 = 1'b1; we1 = 1'b1; addr1 = 6'd7; wdata1 = 8'h3C;
      do_cycle();
      req1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 6'd7;
      do_cycle();
      idle(3);

      // Randomized traffic on a narrow address window for frequent hazards.
      for (int it = 0; it < 400; it++) begin
         if (!req0 && $urandom_range(0, 1) == 1) begin
            req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
            addr0 = 6'($urandom_range(0, 7)); wdata0 = 8'($urandom);
         end
         if (!req1 && $urandom_range(0, 1) == 1) begin
            req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
            addr1 = 6'($urandom_range(0, 7)); wdata1 = 8'($urandom);
         end
         do_cycle();
         if (g0) req0 = 1'b0;
         if (g1) req1 = 1'b0;
      end
      idle(3);
      chk("rq_drained", 32'(rq.size()), 32'd0);

      // Read accepted, then asynchronous reset one cycle later kills the return.
      req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
      do_cycle();
      req0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      rq.delete();
      run_model = 1'b0; last_model = 1'b1; exp_rdata = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_rv0", 32'(rvalid0), 32'd0);
         chk("rst_we", 32'(ram_we), 32'd0);
      end
      rst_n = 1'b1;
      run_init(1'b0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule
